bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/serializer_pkg.sv | 15 +
 rtl/bit_counter.sv | 27 ++
 rtl/bit_serializer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - state encoding and default constants for bit_serializer
package serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_GAP    = 0;
    localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - loadable down-counter with terminal-count flag
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial shifter with optional gap and parity
// Optional even-parity bit after each word: define BIT_SERIALIZER_PARITY_EN.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = DEFAULT_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam int                   CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]     BIT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit                   HAS_GAP  = (GAP > 0);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              x_q, x_d;
    logic              xv_q, xv_d;
    logic              bit_load, bit_dec, bit_tc;
    logic              gap_load, gap_dec, gap_tc;
    logic              final_cycle, accept;
    logic              first_bit, next_bit;
    logic [DATA_W-1:0] sr_load, sr_shift;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic par_q, par_d;
    assign final_cycle = (state_q == ST_PARITY);
`else
    assign final_cycle = (state_q == ST_SHIFT) && bit_tc;
`endif

    // Accepting during the last output cycle lets words stream without a bubble.
    assign in_ready = !rst && ((state_q == ST_IDLE) || (!HAS_GAP && final_cycle));
    assign accept   = in_valid && in_ready;
    assign done     = final_cycle;
    assign busy     = (state_q != ST_IDLE);
    assign x        = x_q;
    assign x_valid  = xv_q;

    assign first_bit = (MSB_FIRST != 0) ? in_data[DATA_W-1] : in_data[0];
    assign sr_load   = (MSB_FIRST != 0) ? (in_data << 1) : (in_data >> 1);
    assign next_bit  = (MSB_FIRST != 0) ? sr_q[DATA_W-1] : sr_q[0];
    assign sr_shift  = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        x_d      = 1'b0;
        xv_d     = 1'b0;
        bit_load = 1'b0;
        bit_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d    = par_q;
`endif
        if (accept) begin
            state_d  = ST_SHIFT;
            sr_d     = sr_load;
            x_d      = first_bit;
            xv_d     = 1'b1;
            bit_load = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d    = ^in_data;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (!bit_tc) begin
                        x_d     = next_bit;
                        xv_d    = 1'b1;
                        sr_d    = sr_shift;
                        bit_dec = 1'b1;
                    end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_d = ST_PARITY;
                        x_d     = par_q;
                        xv_d    = 1'b1;
`else
                        if (HAS_GAP) begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
`endif
                    end
                end
`ifdef BIT_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    if (HAS_GAP) begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                ST_GAP: begin
                    if (gap_tc) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    bit_counter #(.W(CNT_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bit_load),
        .load_val_i (BIT_LOAD),
        .dec_i      (bit_dec),
        .tc_o       (bit_tc)
    );

    bit_counter #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .tc_o       (gap_tc)
    );

endmodule
